// File: rtl/uart_serial_port.sv
// 8051 serial port (SCON/SBUF engine): full-duplex UART timed by Timer 1 overflow ticks.
// Define UART_9BIT_EN to build the SM0-selected 9-bit frame (TB8 transmitted, bit 9 -> rb8).
module uart_serial_port #(
    parameter int OVS     = 16,
    parameter int SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scon,
    input  logic       smod,
    input  logic       t1_ovf,
    input  logic       sbuf_wr,
    input  logic [7:0] sbuf_wdata,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data,
    output logic       rb8,
    output logic       ti_set,
    output logic       ri_set,
    output logic       tx_busy
);
    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] SMP_A    = CW'(7);
    localparam logic [CW-1:0] SMP_B    = CW'(8);
    localparam logic [CW-1:0] SMP_C    = CW'(9);

    typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_DATA, T_BIT9, T_STOP} tx_state_e;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_BIT9, R_STOP} rx_state_e;

    logic               presc_q, presc_d, tick;
    tx_state_e          tx_state_q, tx_state_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic               txd_q, txd_d, ti_set_q, ti_set_d;
    rx_state_e          rx_state_q, rx_state_d;
    logic [SYNC_FF-1:0] rx_sync_q, rx_sync_d;
    logic               rx_prev_q, rxd_s, vote, rx_b8;
    logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [1:0]         rx_smp_q, rx_smp_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic               rb8_q, rb8_d, ri_set_q, ri_set_d;
    logic               unused_scon;

`ifdef UART_9BIT_EN
    logic tx_nine_q, tx_nine_d, tx_b9_q, tx_b9_d;
    logic rx_nine_q, rx_nine_d, rx_b9_q, rx_b9_d;
    assign unused_scon = ^{scon[6], scon[2:1]};
    assign rx_b8       = rx_nine_q ? rx_b9_q : vote;
`else
    assign unused_scon = ^{scon[7:6], scon[3:1]};
    assign rx_b8       = vote;
`endif

    // smod=0 halves the tick rate by only passing every second overflow
    assign presc_d   = t1_ovf ? ~presc_q : presc_q;
    assign tick      = t1_ovf & (smod | presc_q);
    assign rx_sync_d = {rx_sync_q[SYNC_FF-2:0], rxd};
    assign rxd_s     = rx_sync_q[SYNC_FF-1];
    assign vote      = (rx_smp_q[1] & rx_smp_q[0]) | (rx_smp_q[1] & rxd_s) | (rx_smp_q[0] & rxd_s);

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q    <= 1'b0;
            tx_state_q <= T_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b1;
            ti_set_q   <= 1'b0;
            rx_state_q <= R_IDLE;
            rx_sync_q  <= '1;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_smp_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rb8_q      <= 1'b0;
            ri_set_q   <= 1'b0;
`ifdef UART_9BIT_EN
            tx_nine_q  <= 1'b0;
            tx_b9_q    <= 1'b0;
            rx_nine_q  <= 1'b0;
            rx_b9_q    <= 1'b0;
`endif
        end else begin
            presc_q    <= presc_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
            txd_q      <= txd_d;
            ti_set_q   <= ti_set_d;
            rx_state_q <= rx_state_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rxd_s;
            rx_cnt_q   <= rx_cnt_d;
            rx_smp_q   <= rx_smp_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rb8_q      <= rb8_d;
            ri_set_q   <= ri_set_d;
`ifdef UART_9BIT_EN
            tx_nine_q  <= tx_nine_d;
            tx_b9_q    <= tx_b9_d;
            rx_nine_q  <= rx_nine_d;
            rx_b9_q    <= rx_b9_d;
`endif
        end
    end

    // TX: WAIT holds a loaded byte until the next tick so a tick coincident with the load is not used
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        txd_d      = txd_q;
        ti_set_d   = 1'b0;
`ifdef UART_9BIT_EN
        tx_nine_d  = tx_nine_q;
        tx_b9_d    = tx_b9_q;
`endif
        case (tx_state_q)
            T_IDLE: if (sbuf_wr) begin
                tx_shift_d = sbuf_wdata;
                tx_state_d = T_WAIT;
`ifdef UART_9BIT_EN
                tx_nine_d  = scon[7];
                tx_b9_d    = scon[3];
`endif
            end
            T_WAIT: if (tick) begin
                tx_state_d = T_START;
                txd_d      = 1'b0;
                tx_cnt_d   = CNT_LAST;
            end
            default: if (tick) begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end else begin
                    tx_cnt_d = CNT_LAST;
                    case (tx_state_q)
                        T_START: begin
                            tx_state_d = T_DATA;
                            tx_bit_d   = '0;
                            txd_d      = tx_shift_q[0];
                        end
                        T_DATA: begin
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            tx_bit_d   = tx_bit_q + 3'd1;
                            txd_d      = tx_shift_q[1];
                            if (tx_bit_q == 3'd7) begin
                                tx_state_d = T_STOP;
                                txd_d      = 1'b1;
                                ti_set_d   = 1'b1;
`ifdef UART_9BIT_EN
                                if (tx_nine_q) begin
                                    tx_state_d = T_BIT9;
                                    txd_d      = tx_b9_q;
                                    ti_set_d   = 1'b0;
                                end
`endif
                            end
                        end
`ifdef UART_9BIT_EN
                        T_BIT9: begin
                            tx_state_d = T_STOP;
                            txd_d      = 1'b1;
                            ti_set_d   = 1'b1;
                        end
`endif
                        default: tx_state_d = T_IDLE;
                    endcase
                end
            end
        endcase
    end

    // RX: each bit is resolved at sample 9; the stop bit decides acceptance and ends the frame there
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_smp_d   = rx_smp_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rb8_d      = rb8_q;
        ri_set_d   = 1'b0;
`ifdef UART_9BIT_EN
        rx_nine_d  = rx_nine_q;
        rx_b9_d    = rx_b9_q;
`endif
        if (rx_state_q == R_IDLE) begin
            if (scon[4] && rx_prev_q && !rxd_s) begin
                rx_state_d = R_START;
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
            end
        end else if (tick) begin
            rx_cnt_d = (rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + CW'(1);
            if (rx_cnt_q == SMP_A) rx_smp_d[1] = rxd_s;
            if (rx_cnt_q == SMP_B) rx_smp_d[0] = rxd_s;
            if (rx_cnt_q == SMP_C) begin
                case (rx_state_q)
                    R_START: if (vote) rx_state_d = R_IDLE;
                    R_DATA:  rx_shift_d = {vote, rx_shift_q[7:1]};
`ifdef UART_9BIT_EN
                    R_BIT9:  rx_b9_d = vote;
`endif
                    R_STOP: begin
                        rx_state_d = R_IDLE;
                        if (!scon[0] && (!scon[5] || rx_b8)) begin
                            rx_data_d = rx_shift_q;
                            rb8_d     = rx_b8;
                            ri_set_d  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (rx_cnt_q == CNT_LAST) begin
                case (rx_state_q)
                    R_START: begin
                        rx_state_d = R_DATA;
                        rx_bit_d   = '0;
                    end
                    R_DATA: begin
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = R_STOP;
`ifdef UART_9BIT_EN
                            rx_nine_d = scon[7];
                            if (scon[7]) rx_state_d = R_BIT9;
`endif
                        end
                    end
`ifdef UART_9BIT_EN
                    R_BIT9: rx_state_d = R_STOP;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tx_busy = (tx_state_q != T_IDLE);
        txd     = txd_q;
        ti_set  = ti_set_q;
        ri_set  = ri_set_q;
        rx_data = rx_data_q;
        rb8     = rb8_q;
    end
endmodule

// File: tb/tb_uart_serial_port.sv
// Directed bench for uart_serial_port: tx waveform, loopback receive, RI/SM2 gating, false start, reset abort.
module tb_uart_serial_port;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scon = 8'h00;
    logic       smod = 1'b1;
    logic       t1_ovf = 1'b1;
    logic       sbuf_wr = 1'b0;
    logic [7:0] sbuf_wdata = 8'h00;
    logic       loop_en = 1'b0;
    logic       rxd_man = 1'b1;
    logic       rxd_w;
    logic       txd, rb8, ti_set, ri_set, tx_busy;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int ti_cnt = 0;
    int ri_cnt = 0;
    int ti_at  = 0;
    int n, z;
    logic [9:0] exp_bits;

    assign rxd_w = loop_en ? txd : rxd_man;

    uart_serial_port dut (
        .clk        (clk),
        .reset      (reset),
        .scon       (scon),
        .smod       (smod),
        .t1_ovf     (t1_ovf),
        .sbuf_wr    (sbuf_wr),
        .sbuf_wdata (sbuf_wdata),
        .rxd        (rxd_w),
        .txd        (txd),
        .rx_data    (rx_data),
        .rb8        (rb8),
        .ti_set     (ti_set),
        .ri_set     (ri_set),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk); #1;
            if (ti_set === 1'b1) ti_cnt++;
            if (ri_set === 1'b1) ri_cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        sbuf_wdata = b;
        sbuf_wr    = 1'b1;
        run_cycles(1);
        sbuf_wr    = 1'b0;
    endtask

    // bits[0] is the start bit; each bit held one bit period at smod=1
    task automatic drive_frame(input logic [10:0] bits, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            rxd_man = bits[b];
            run_cycles(16);
        end
        rxd_man = 1'b1;
    endtask

    initial begin
        run_cycles(3);
        check_eq("rst_txd", txd, 1);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_rb8", rb8, 0);
        check_eq("rst_ti", ti_set, 0);
        check_eq("rst_ri", ri_set, 0);
        check_eq("rst_busy", tx_busy, 0);
        reset = 1'b1;
        run_cycles(2);

        // 1: 0xA5 waveform at one tick per clock
        exp_bits = 10'b1101001010;
        ti_cnt = 0;
        ti_at  = 0;
        sbuf_wdata = 8'hA5;
        sbuf_wr    = 1'b1;
        @(posedge clk); #1;
        sbuf_wr    = 1'b0;
        check_eq("t1_busy_load", tx_busy, 1);
        for (int c = 1; c <= 170; c++) begin
            @(posedge clk); #1;
            if (ti_set === 1'b1) begin
                ti_cnt++;
                ti_at = c;
            end
            if (c >= 9 && c <= 153 && ((c - 9) % 16) == 0)
                check_eq($sformatf("t1_bit%0d", (c - 9) / 16), txd, exp_bits[(c - 9) / 16]);
            if (c == 160) check_eq("t1_busy_160", tx_busy, 1);
            if (c == 161) check_eq("t1_busy_161", tx_busy, 0);
        end
        check_eq("t1_ti_count", ti_cnt, 1);
        check_eq("t1_ti_cycle", ti_at, 145);

        // 2: loopback 0x3C
        loop_en = 1'b1;
        scon = 8'h10;
        ti_cnt = 0; ri_cnt = 0;
        send_byte(8'h3C);
        run_cycles(200);
        check_eq("t2_ri_count", ri_cnt, 1);
        check_eq("t2_rx_data", rx_data, 8'h3C);
        check_eq("t2_rb8", rb8, 1);

        // 3: RI held blocks reception; clearing it allows the next byte
        scon = 8'h11;
        ri_cnt = 0;
        send_byte(8'h55);
        run_cycles(200);
        check_eq("t3_ri_blocked", ri_cnt, 0);
        check_eq("t3_rx_kept", rx_data, 8'h3C);
        scon = 8'h10;
        send_byte(8'h66);
        run_cycles(200);
        check_eq("t3_ri_count", ri_cnt, 1);
        check_eq("t3_rx_data", rx_data, 8'h66);

        // 4: short low glitch is a false start
        loop_en = 1'b0;
        ri_cnt = 0;
        rxd_man = 1'b0;
        run_cycles(4);
        rxd_man = 1'b1;
        run_cycles(40);
        check_eq("t4_false_start", ri_cnt, 0);
        check_eq("t4_rx_kept", rx_data, 8'h66);
        loop_en = 1'b1;
        send_byte(8'h81);
        run_cycles(200);
        check_eq("t4_ri_count", ri_cnt, 1);
        check_eq("t4_rx_data", rx_data, 8'h81);

        // 5: smod=0 doubles bit period; write during frame ignored
        smod = 1'b0;
        ti_cnt = 0; ri_cnt = 0;
        send_byte(8'hC3);
        n = 0;
        while (txd !== 1'b0 && n < 100) begin run_cycles(1); n++; end
        check_eq("t5_start_seen", txd, 0);
        z = 0;
        while (txd === 1'b0 && z < 100) begin run_cycles(1); z++; end
        check_eq("t5_start_len", z, 32);
        send_byte(8'hFF);
        run_cycles(400);
        check_eq("t5_ti_count", ti_cnt, 1);
        check_eq("t5_ri_count", ri_cnt, 1);
        check_eq("t5_rx_data", rx_data, 8'hC3);
        check_eq("t5_busy_end", tx_busy, 0);
        smod = 1'b1;

        // SM2 in 8-bit mode tests the stop bit; a framing error is still taken with SM2=0
        loop_en = 1'b0;
        ri_cnt = 0;
        scon = 8'h30;
        drive_frame({1'b0, 1'b0, 8'h5A, 1'b0}, 10);
        run_cycles(40);
        check_eq("sm2_stop0_drop", ri_cnt, 0);
        check_eq("sm2_rx_kept", rx_data, 8'hC3);
        scon = 8'h10;
        drive_frame({1'b0, 1'b0, 8'hA7, 1'b0}, 10);
        run_cycles(40);
        check_eq("ferr_ri_count", ri_cnt, 1);
        check_eq("ferr_rx_data", rx_data, 8'hA7);
        check_eq("ferr_rb8", rb8, 0);

`ifdef UART_9BIT_EN
        // 6: 9-bit multiprocessor filtering on TB8
        loop_en = 1'b1;
        ri_cnt = 0;
        scon = 8'hB0;
        send_byte(8'h12);
        run_cycles(220);
        check_eq("t6_tb8_0_drop", ri_cnt, 0);
        check_eq("t6_rx_kept", rx_data, 8'hA7);
        scon = 8'hB8;
        send_byte(8'h34);
        run_cycles(220);
        check_eq("t6_ri_count", ri_cnt, 1);
        check_eq("t6_rx_data", rx_data, 8'h34);
        check_eq("t6_rb8", rb8, 1);
`endif

        // reset mid-frame aborts both directions
        loop_en = 1'b1;
        scon = 8'h10;
        send_byte(8'h99);
        run_cycles(60);
        reset = 1'b0;
        run_cycles(1);
        check_eq("rst_mid_txd", txd, 1);
        check_eq("rst_mid_busy", tx_busy, 0);
        check_eq("rst_mid_rx_data", rx_data, 0);
        reset = 1'b1;
        ti_cnt = 0; ri_cnt = 0;
        run_cycles(200);
        check_eq("rst_mid_no_ti", ti_cnt, 0);
        check_eq("rst_mid_no_ri", ri_cnt, 0);
        check_eq("rst_mid_txd_idle", txd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
